// File: rtl/div_ctrl.sv
// Request/response controller around a fixed-latency external divider: a shadow pipe
// tracks each request to the divider output, results land in a show-ahead FIFO under credit flow control.
module div_ctrl #(
    parameter int LATENCY    = 4,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_src,
    input  logic [31:0]      req_sink,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      div_src,
    output logic [31:0]      div_sink,
    input  logic [31:0]      div_quo,
    input  logic [31:0]      div_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_quo,
    output logic [31:0]      rsp_res,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dz,
    output logic             busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LAST  = LATENCY;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic                       accept_s;
    logic                       push_s;
    logic                       pop_s;
    logic [31:0]                div_src_q, div_src_d;
    logic [31:0]                div_sink_q, div_sink_d;
    logic [LAST:0]              pipe_vld_q, pipe_vld_d;
    logic [LAST:0]              pipe_dz_q, pipe_dz_d;
    logic [LAST:0][TAG_W-1:0]   pipe_tag_q, pipe_tag_d;
    logic [LAST:0][31:0]        pipe_src_q, pipe_src_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [CNT_W-1:0]           occ_q, occ_d;
    logic [CNT_W-1:0]           outst_q, outst_d;
    logic [31:0]                push_quo_s;
    logic [31:0]                push_res_s;
    logic [31:0]                mem_quo_q [FIFO_DEPTH];
    logic [31:0]                mem_res_q [FIFO_DEPTH];
    logic [TAG_W-1:0]           mem_tag_q [FIFO_DEPTH];
    logic                       mem_dz_q  [FIFO_DEPTH];

    // Outstanding = in flight + buffered, so a push can never find the buffer full.
    assign req_ready = (outst_q < DEPTH_C);
    assign accept_s  = req_valid && req_ready;
    assign push_s    = pipe_vld_q[LAST];
    assign pop_s     = rsp_valid && rsp_ready;

    assign div_src   = div_src_q;
    assign div_sink  = div_sink_q;
    assign rsp_valid = (occ_q != {CNT_W{1'b0}});
    assign rsp_quo   = mem_quo_q[rptr_q];
    assign rsp_res   = mem_res_q[rptr_q];
    assign rsp_tag   = mem_tag_q[rptr_q];
    assign rsp_dz    = mem_dz_q[rptr_q];
    assign busy      = (|pipe_vld_q) || rsp_valid;

    // Divider operands: captured on accept, held otherwise.
    always_comb begin
        div_src_d  = div_src_q;
        div_sink_d = div_sink_q;
        if (accept_s) begin
            div_src_d  = req_src;
            div_sink_d = req_sink;
        end else begin
            div_src_d  = div_src_q;
            div_sink_d = div_sink_q;
        end
    end

    // Tracking pipe next state: free-running shift, stage 0 takes the accepted request.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_dz_d     = pipe_dz_q;
        pipe_tag_d    = pipe_tag_q;
        pipe_src_d    = pipe_src_q;
        pipe_vld_d[0] = accept_s;
        pipe_dz_d[0]  = (req_sink == 32'd0);
        pipe_tag_d[0] = req_tag;
        pipe_src_d[0] = req_src;
        for (int i = 1; i <= LAST; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_dz_d[i]  = pipe_dz_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
            pipe_src_d[i] = pipe_src_q[i-1];
        end
    end

    // Result selection: a zero divisor overrides whatever the divider produced.
    always_comb begin
        push_quo_s = div_quo;
        push_res_s = div_res;
        if (pipe_dz_q[LAST]) begin
            push_quo_s = 32'hFFFF_FFFF;
            push_res_s = pipe_src_q[LAST];
        end else begin
            push_quo_s = div_quo;
            push_res_s = div_res;
        end
    end

    // Buffer pointers and occupancy / outstanding counters.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_s) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        case ({accept_s, pop_s})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_src_q  <= 32'd0;
            div_sink_q <= 32'd0;
            pipe_vld_q <= '0;
            pipe_dz_q  <= '0;
            pipe_tag_q <= '0;
            pipe_src_q <= '0;
            wptr_q     <= {PTR_W{1'b0}};
            rptr_q     <= {PTR_W{1'b0}};
            occ_q      <= {CNT_W{1'b0}};
            outst_q    <= {CNT_W{1'b0}};
        end else begin
            div_src_q  <= div_src_d;
            div_sink_q <= div_sink_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_dz_q  <= pipe_dz_d;
            pipe_tag_q <= pipe_tag_d;
            pipe_src_q <= pipe_src_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
        end
    end

    // Result storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_quo_q[wptr_q] <= push_quo_s;
            mem_res_q[wptr_q] <= push_res_s;
            mem_tag_q[wptr_q] <= pipe_tag_q[LAST];
            mem_dz_q[wptr_q]  <= pipe_dz_q[LAST];
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomised bench for div_ctrl with a behavioural fixed-latency divider.
module tb_div_ctrl;
    localparam int LAT   = 4;
    localparam int TW    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_src;
    logic [31:0]   req_sink;
    logic [TW-1:0] req_tag;
    logic [31:0]   div_src;
    logic [31:0]   div_sink;
    logic [31:0]   div_quo;
    logic [31:0]   div_res;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_quo;
    logic [31:0]   rsp_res;
    logic [TW-1:0] rsp_tag;
    logic          rsp_dz;
    logic          busy;

    always #5 clk = ~clk;

    div_ctrl #(.LATENCY(LAT), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_sink(req_sink), .req_tag(req_tag),
        .div_src(div_src), .div_sink(div_sink),
        .div_quo(div_quo), .div_res(div_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quo(rsp_quo), .rsp_res(rsp_res), .rsp_tag(rsp_tag), .rsp_dz(rsp_dz),
        .busy(busy)
    );

    // Divider stand-in: result of the current operands appears LAT edges later; garbage on /0.
    logic [31:0] mq [LAT];
    logic [31:0] mr [LAT];
    always @(posedge clk) begin
        if (div_sink == 32'd0) begin
            mq[0] <= 32'hDEADBEEF;
            mr[0] <= 32'hCAFEF00D;
        end else begin
            mq[0] <= div_src / div_sink;
            mr[0] <= div_src % div_sink;
        end
        for (int i = 1; i < LAT; i++) begin
            mq[i] <= mq[i-1];
            mr[i] <= mr[i-1];
        end
    end
    assign div_quo = mq[LAT-1];
    assign div_res = mr[LAT-1];

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int pop_cnt  = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [31:0]   quo;
        logic [31:0]   res;
        logic [TW-1:0] tag;
        logic          dz;
    } rsp_t;

    function automatic rsp_t model(input logic [31:0] s, input logic [31:0] k, input logic [TW-1:0] t);
        rsp_t r;
        if (k == 32'd0) begin
            r.quo = 32'hFFFFFFFF;
            r.res = s;
            r.dz  = 1'b1;
        end else begin
            r.quo = s / k;
            r.res = s % k;
            r.dz  = 1'b0;
        end
        r.tag = t;
        return r;
    endfunction

    // Scoreboard: expected result queued on each accept, compared in order on each transfer.
    rsp_t exp_q[$];
    rsp_t mon_e;
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got tag %0h expected no response", rsp_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_rsp", 96'({rsp_quo, rsp_res, rsp_tag, rsp_dz}), 96'(mon_e));
                end
            end
            if (req_valid && req_ready) begin
                acc_cnt++;
                exp_q.push_back(model(req_src, req_sink, req_tag));
            end
        end
    end

    task automatic drain(input string name);
        int c;
        c = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (busy && c < 200) begin
            step();
            c++;
        end
        chk(name, 96'(busy), 96'(0));
    endtask

    typedef struct {
        logic [31:0]   src;
        logic [31:0]   sink;
        logic [TW-1:0] tag;
        logic [31:0]   quo;
        logic [31:0]   res;
        logic          dz;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int cyc, n, stall, stale, a0, p0, r;
        logic acc;

        vecs[0] = '{32'd100,        32'd7,          4'd3,  32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'h00001234,   32'd0,          4'd5,  32'hFFFFFFFF,   32'h00001234,   1'b1};
        vecs[2] = '{32'd0,          32'd5,          4'd1,  32'd0,          32'd0,          1'b0};
        vecs[3] = '{32'd5,          32'd10,         4'd2,  32'd0,          32'd5,          1'b0};
        vecs[4] = '{32'hFFFFFFFF,   32'd1,          4'd15, 32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   4'd7,  32'd1,          32'd0,          1'b0};
        vecs[6] = '{32'd1000,       32'd3,          4'd0,  32'd333,        32'd1,          1'b0};
        vecs[7] = '{32'd0,          32'd0,          4'd12, 32'hFFFFFFFF,   32'd0,          1'b1};

        rstn = 1'b0; req_valid = 1'b0; req_src = 32'd0; req_sink = 32'd0;
        req_tag = '0; rsp_ready = 1'b0;
        step(); step();
        chk("rst_state", 96'({rsp_valid, busy, div_src, div_sink}), 96'(0));
        rstn = 1'b1;
        chk("rst_ready", 96'(req_ready), 96'(1));

        // Single requests from the table: latency, fields, then drained.
        for (int v = 0; v < 8; v++) begin
            req_valid = 1'b1; req_src = vecs[v].src; req_sink = vecs[v].sink;
            req_tag = vecs[v].tag; rsp_ready = 1'b1;
            chk("vec_ready", 96'(req_ready), 96'(1));
            step();
            req_valid = 1'b0;
            chk("vec_div_ops", 96'({div_src, div_sink}), 96'({vecs[v].src, vecs[v].sink}));
            cyc = 0;
            while (!rsp_valid && cyc < 20) begin
                step();
                cyc++;
            end
            chk("vec_latency", 96'(cyc), 96'(5));
            chk("vec_rsp", 96'({rsp_quo, rsp_res, rsp_tag, rsp_dz}),
                96'({vecs[v].quo, vecs[v].res, vecs[v].tag, vecs[v].dz}));
            step();
            chk("vec_drained", 96'({rsp_valid, busy}), 96'(0));
        end

        // Backpressure: credits run out at DEPTH, then drain in tag order.
        rsp_ready = 1'b0; req_valid = 1'b1; n = 0;
        for (int i = 0; i < 14; i++) begin
            req_tag = TW'(n); req_src = 32'(200 + n); req_sink = 32'd3;
            acc = req_ready;
            step();
            if (acc) n++;
        end
        req_valid = 1'b0;
        chk("bp_accepts", 96'(n), 96'(8));
        chk("bp_ready_low", 96'(req_ready), 96'(0));
        chk("bp_head", 96'({rsp_valid, rsp_tag}), 96'({1'b1, 4'd0}));
        rsp_ready = 1'b1;
        step();
        chk("bp_ready_back", 96'(req_ready), 96'(1));
        for (int k = 1; k < 8; k++) begin
            chk("bp_order", 96'({rsp_valid, rsp_tag}), 96'({1'b1, 4'(k)}));
            step();
        end
        chk("bp_empty", 96'({rsp_valid, busy}), 96'(0));

        // Streaming: one accept and, after the fill, one result every cycle.
        a0 = acc_cnt; p0 = pop_cnt; stall = 0;
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            req_src = $urandom; req_sink = 32'($urandom_range(1, 1000)); req_tag = TW'(i);
            step();
            if (i >= 5 && !rsp_valid) stall++;
        end
        req_valid = 1'b0;
        chk("st_accepts", 96'(acc_cnt - a0), 96'(50));
        chk("st_stalls", 96'(stall), 96'(0));
        drain("st_drain");
        chk("st_results", 96'(pop_cnt - p0), 96'(50));

        // Reset mid-operation discards everything in flight.
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_src = 32'(300 + i); req_sink = 32'd7; req_tag = TW'(i);
            step();
        end
        req_valid = 1'b0;
        chk("rm_busy_before", 96'(busy), 96'(1));
        rstn = 1'b0;
        #1;
        chk("rm_async_clear", 96'({rsp_valid, busy, div_src, div_sink}), 96'(0));
        step();
        rstn = 1'b1; rsp_ready = 1'b1;
        chk("rm_ready", 96'(req_ready), 96'(1));
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid || busy) stale++;
        end
        chk("rm_no_stale", 96'(stale), 96'(0));

        // Request presented while reset releases is taken at the very first edge.
        rstn = 1'b0;
        step();
        req_valid = 1'b1; req_src = 32'd50; req_sink = 32'd5; req_tag = 4'd9;
        rstn = 1'b1;
        a0 = acc_cnt; p0 = pop_cnt;
        step();
        req_valid = 1'b0;
        chk("rr_first_accept", 96'(acc_cnt - a0), 96'(1));
        drain("rr_drain");
        chk("rr_result", 96'(pop_cnt - p0), 96'(1));

        // Random traffic against the scoreboard.
        a0 = acc_cnt; p0 = pop_cnt; cyc = 0;
        while ((acc_cnt - a0) < 1000 && cyc < 20000) begin
            req_valid = ($urandom_range(0, 9) < 8);
            req_src = $urandom;
            r = int'($urandom_range(0, 9));
            if (r == 0) req_sink = 32'd0;
            else if (r < 5) req_sink = 32'($urandom_range(1, 16));
            else req_sink = $urandom;
            req_tag = TW'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        req_valid = 1'b0;
        chk("rnd_accepts", 96'(acc_cnt - a0), 96'(1000));
        drain("rnd_drain");
        chk("rnd_results", 96'(pop_cnt - p0), 96'(acc_cnt - a0));
        chk("rnd_sb_empty", 96'(exp_q.size()), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4: rising edges after div_src/div_sink change until div_quo/div_res are valid.
REQ-002 SHALL have parameter TAG_W, default 4: request tag width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two, >= LATENCY+1: result buffer entries.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted this cycle if valid.
REQ-008 req_src  in  32  unsigned dividend.
REQ-009 req_sink  in  32  unsigned divisor.
REQ-010 req_tag  in  TAG_W  opaque tag returned with result.
REQ-011 div_src  out  32  dividend to divider.
REQ-012 div_sink  out  32  divisor to divider.
REQ-013 div_quo  in  32  quotient from divider.
REQ-014 div_res  in  32  remainder from divider.
REQ-015 rsp_valid  out  1  result available.
REQ-016 rsp_ready  in  1  consumer takes result.
REQ-017 rsp_quo  out  32  quotient.
REQ-018 rsp_res  out  32  remainder.
REQ-019 rsp_tag  out  TAG_W  tag of request.
REQ-020 rsp_dz  out  1  divisor was zero.
REQ-021 busy  out  1  any request in flight or buffered.

Function
REQ-022 Accept = req_valid && req_ready at a rising edge; transfer = rsp_valid && rsp_ready at a rising edge.
REQ-023 req_ready SHALL be combinational: 1 iff (in-flight count + buffer occupancy) < FIFO_DEPTH; independent of req_valid.
REQ-024 On accept at edge N, div_src/div_sink SHALL load req_src/req_sink at edge N and hold until next accept.
REQ-025 Tracking pipe, LATENCY+1 stages, SHALL carry valid, tag, dz = (req_sink == 0), and src; advance every cycle, no stall.
REQ-026 Last pipe stage valid SHALL push one buffer entry at edge N+LATENCY+1, sampling div_quo/div_res.
REQ-027 Pushed entry with dz=0: quo=div_quo, res=div_res; dz=1: quo=32'hFFFFFFFF, res=carried src, div outputs ignored.
REQ-028 Buffer SHALL be show-ahead FIFO: rsp_* reflect oldest entry; rsp_valid = occupancy != 0.
REQ-029 Min latency: rsp_valid high in the cycle after edge N+LATENCY+1; one result per cycle sustained.
REQ-030 Responses SHALL leave in acceptance order.
REQ-031 Simultaneous push and pop SHALL leave occupancy unchanged; pop from empty SHALL not occur (rsp_valid=0).
REQ-032 Credit rule (REQ-023) SHALL guarantee push never hits a full buffer; no overflow path needed.
REQ-033 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-034 busy = any pipe stage valid || occupancy != 0.
REQ-035 rsp_quo/rsp_res/rsp_tag/rsp_dz SHALL be don't-care when rsp_valid=0.

Reset
REQ-036 rstn low SHALL immediately clear all pipe valids, pointers, occupancy; div_src=0, div_sink=0, rsp_valid=0, busy=0, req_ready=1 after release.
REQ-037 Reset mid-operation SHALL discard all in-flight and buffered requests; none reappear after release.
REQ-038 First edge after rstn rises SHALL accept normally.

Verification
REQ-039 Single: src=100, sink=7, tag=3 at edge N, rsp_ready=1 -> rsp_valid after edge N+5, quo=14, res=2, tag=3, dz=0.
REQ-040 Divide by zero: src=32'h00001234, sink=0 -> quo=32'hFFFFFFFF, res=32'h00001234, dz=1.
REQ-041 Backpressure: rsp_ready=0, req_valid=1 each cycle -> exactly 8 accepts, then req_ready=0; rsp_ready=1 -> 8 results in tag order 0..7, req_ready returns after first pop.
REQ-042 Streaming: req_valid=1, rsp_ready=1 for 50 cycles -> 50 accepts, results 1/cycle after 5-cycle fill, occupancy never exceeds 1.
REQ-043 Reset mid-op: 3 accepts, rstn low 1 cycle -> rsp_valid=0, busy=0; no stale result within next 10 cycles.
REQ-044 Random: 1000 random src/sink (10% sink=0), random rsp_ready -> every result matches src/sink, src%sink (or REQ-027 dz rule) with correct tag, in order.
